// File: rtl/blake2s_host_driver.sv
// Host-side BLAKE2s pin driver: serialises the configuration and padded 64-byte
// blocks onto valid/cmd/data, paces blocks, then captures the returned digest.
`timescale 1ns/1ps
module blake2s_host_driver #(
  parameter int BLOCK_GAP    = 32,
  parameter int HASH_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [7:0]  kk_i,
  input  logic [7:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  output logic        busy_o,
  output logic        hash_v_o,
  output logic [7:0]  hash_o,
  output logic [4:0]  hash_idx_o,
  output logic        done_o,
  output logic        error_o,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  input  logic        hash_finished_i,
  input  logic [7:0]  hash_i
);

  localparam logic [1:0] CMD_CONF = 2'd0;
  localparam logic [1:0] CMD_DATA = 2'd1;
  localparam logic [1:0] CMD_LAST = 2'd2;
  localparam int GW = (BLOCK_GAP > 1) ? $clog2(BLOCK_GAP) : 1;
  localparam int TW = $clog2(HASH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF,
    S_DATA,
    S_GAP,
    S_WAIT_HASH,
    S_READ
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    conf_idx_q, conf_idx_d;
  logic [5:0]    idx_q, idx_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;
  logic [5:0]    nn_q, nn_d;
  logic [63:0]   ll_q, ll_d;
  logic [64:0]   total_q, total_d;
  logic [64:0]   consumed_q, consumed_d;
  logic [64:0]   block_base_q, block_base_d;

  logic          valid_q, valid_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    data_q, data_d;
  logic          s_ready_q, s_ready_d;
  logic          busy_q, busy_d;
  logic          hash_v_q, hash_v_d;
  logic [7:0]    hash_q, hash_d;
  logic [4:0]    hash_idx_q, hash_idx_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic [7:0]    ll_byte [8];
  logic [2:0]    conf_sel;
  logic [5:0]    nn_clamped;
  logic [65:0]   blk_end;
  logic          is_final;
  logic          have_data;
  logic          xfer;

  for (genvar gi = 0; gi < 8; gi++) begin : g_ll_byte
    assign ll_byte[gi] = ll_q[8*gi +: 8];
  end

  // conf_idx_q is the beat currently on the pins; the next ll byte is conf_idx_q-1
  assign conf_sel   = conf_idx_q[2:0] - 3'd1;
  assign nn_clamped = ((nn_i == 8'd0) || (nn_i > 8'd32)) ? 6'd32 : nn_i[5:0];

  // The current block is final when the stream ends inside it (or is empty)
  assign blk_end   = {1'b0, block_base_q} + 66'd64;
  assign is_final  = ({1'b0, total_q} <= blk_end);
  assign have_data = (consumed_q < total_q);
  assign xfer      = s_valid_i & s_ready_q;

  always_comb begin
    state_d      = state_q;
    conf_idx_d   = conf_idx_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    nn_d         = nn_q;
    ll_d         = ll_q;
    total_d      = total_q;
    consumed_d   = consumed_q;
    block_base_d = block_base_q;
    valid_d      = 1'b0;
    cmd_d        = CMD_CONF;
    data_d       = 8'd0;
    hash_v_d     = 1'b0;
    hash_d       = 8'd0;
    hash_idx_d   = 5'd0;
    done_d       = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_CONF;
          nn_d         = nn_clamped;
          ll_d         = ll_i;
          total_d      = {1'b0, ll_i} + ((kk_i != 8'd0) ? 65'd64 : 65'd0);
          consumed_d   = 65'd0;
          block_base_d = 65'd0;
          idx_d        = 6'd0;
          conf_idx_d   = 4'd0;
          valid_d      = 1'b1;
          data_d       = kk_i;
        end
      end

      S_CONF: begin
        if (conf_idx_q == 4'd9) begin
          state_d = S_DATA;
        end else begin
          valid_d    = 1'b1;
          conf_idx_d = conf_idx_q + 4'd1;
          data_d     = (conf_idx_q == 4'd0) ? {2'b00, nn_q} : ll_byte[conf_sel];
        end
      end

      S_DATA: begin
        // Real bytes wait for the source; pad bytes go out every cycle
        if (!have_data || xfer) begin
          valid_d = 1'b1;
          cmd_d   = is_final ? CMD_LAST : CMD_DATA;
          data_d  = have_data ? s_data_i : 8'd0;
          idx_d   = idx_q + 6'd1;
          if (have_data) begin
            consumed_d = consumed_q + 65'd1;
          end
          if (idx_q == 6'd63) begin
            if (is_final) begin
              state_d    = S_WAIT_HASH;
              wait_cnt_d = '0;
            end else begin
              state_d      = S_GAP;
              gap_cnt_d    = '0;
              block_base_d = block_base_q + 65'd64;
            end
          end
        end
      end

      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(BLOCK_GAP - 1)) begin
          state_d = S_DATA;
        end
      end

      S_WAIT_HASH: begin
        // The first cycle here still shows the final beat, so it is not counted
        wait_cnt_d = wait_cnt_q + TW'(1);
        if ((wait_cnt_q != '0) && hash_finished_i) begin
          state_d    = S_READ;
          hash_v_d   = 1'b1;
          hash_d     = hash_i;
          hash_idx_d = 5'd0;
          rd_cnt_d   = 6'd1;
        end else if (wait_cnt_q == TW'(HASH_TIMEOUT)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end

      S_READ: begin
        if (rd_cnt_q == nn_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!hash_finished_i) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          hash_v_d   = 1'b1;
          hash_d     = hash_i;
          hash_idx_d = rd_cnt_q[4:0];
          rd_cnt_d   = rd_cnt_q + 6'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    s_ready_d = (state_d == S_DATA) && (consumed_d < total_q);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      conf_idx_q   <= 4'd0;
      idx_q        <= 6'd0;
      gap_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      rd_cnt_q     <= 6'd0;
      nn_q         <= 6'd0;
      ll_q         <= 64'd0;
      total_q      <= 65'd0;
      consumed_q   <= 65'd0;
      block_base_q <= 65'd0;
      valid_q      <= 1'b0;
      cmd_q        <= 2'd0;
      data_q       <= 8'd0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      hash_v_q     <= 1'b0;
      hash_q       <= 8'd0;
      hash_idx_q   <= 5'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      conf_idx_q   <= conf_idx_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      nn_q         <= nn_d;
      ll_q         <= ll_d;
      total_q      <= total_d;
      consumed_q   <= consumed_d;
      block_base_q <= block_base_d;
      valid_q      <= valid_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      hash_v_q     <= hash_v_d;
      hash_q       <= hash_d;
      hash_idx_q   <= hash_idx_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign valid_o    = valid_q;
  assign cmd_o      = cmd_q;
  assign data_o     = data_q;
  assign s_ready_o  = s_ready_q;
  assign busy_o     = busy_q;
  assign hash_v_o   = hash_v_q;
  assign hash_o     = hash_q;
  assign hash_idx_o = hash_idx_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_blake2s_host_driver.sv
// Directed bench for blake2s_host_driver: config beats, block framing and pacing,
// upstream stalls, digest capture, hash timeout and mid-job reset.
`timescale 1ns/1ps
module tb_blake2s_host_driver;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start_i;
  logic [7:0]  kk_i;
  logic [7:0]  nn_i;
  logic [63:0] ll_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o;
  logic        busy_o;
  logic        hash_v_o;
  logic [7:0]  hash_o;
  logic [4:0]  hash_idx_o;
  logic        done_o;
  logic        error_o;
  logic        valid_o;
  logic [1:0]  cmd_o;
  logic [7:0]  data_o;
  logic        hash_finished_i;
  logic [7:0]  hash_i;

  always #5 clk = ~clk;

  blake2s_host_driver #(
    .BLOCK_GAP   (32),
    .HASH_TIMEOUT(4095)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .start_i        (start_i),
    .kk_i           (kk_i),
    .nn_i           (nn_i),
    .ll_i           (ll_i),
    .s_valid_i      (s_valid_i),
    .s_data_i       (s_data_i),
    .s_ready_o      (s_ready_o),
    .busy_o         (busy_o),
    .hash_v_o       (hash_v_o),
    .hash_o         (hash_o),
    .hash_idx_o     (hash_idx_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .valid_o        (valid_o),
    .cmd_o          (cmd_o),
    .data_o         (data_o),
    .hash_finished_i(hash_finished_i),
    .hash_i         (hash_i)
  );

  logic [28:0] outs_w;
  assign outs_w = {valid_o, cmd_o, data_o, s_ready_o, busy_o, hash_v_o, hash_o,
                   hash_idx_o, done_o, error_o};

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] src    [256];
  logic [1:0] b_cmd  [256];
  logic [7:0] b_data [256];
  int         b_cyc  [256];
  int         nbeats;
  int         nlast;
  bit         ready_seen;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nn_exp(input logic [7:0] n);
    return ((n == 8'd0) || (n > 8'd32)) ? 32 : int'(n);
  endfunction

  // Starts a job, checks the 10 CONF beats, then feeds the stream and records beats
  task automatic run_job(input logic [7:0] kk, input logic [7:0] nn, input logic [63:0] ll,
                         input int stall_at, input int stall_len, input int abort_at);
    int          cyc;
    int          src_pos;
    int          stall_left;
    logic [7:0]  exp_conf;
    logic [63:0] ll_sh;
    @(negedge clk);
    kk_i = kk; nn_i = nn; ll_i = ll; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    kk_i = 8'hFF; nn_i = 8'hFF; ll_i = '1;
    check_eq("busy_after_start", 64'(busy_o), 64'd1);
    for (int b = 0; b < 10; b++) begin
      if (b > 0) @(negedge clk);
      if (b == 0) exp_conf = kk;
      else if (b == 1) exp_conf = 8'(nn_exp(nn));
      else begin
        ll_sh    = ll >> (8 * (b - 2));
        exp_conf = ll_sh[7:0];
      end
      check_eq("conf_valid", 64'(valid_o), 64'd1);
      check_eq("conf_cmd", 64'(cmd_o), 64'd0);
      check_eq("conf_data", 64'(data_o), 64'(exp_conf));
    end
    cyc = 0; nbeats = 0; nlast = 0; ready_seen = 1'b0; src_pos = 0; stall_left = stall_len;
    while (nlast < 64 && cyc < 3000 && !(abort_at > 0 && nbeats >= abort_at)) begin
      @(negedge clk);
      cyc++;
      if (valid_o && nbeats < 256) begin
        b_cmd[nbeats]  = cmd_o;
        b_data[nbeats] = data_o;
        b_cyc[nbeats]  = cyc;
        nbeats++;
        if (cmd_o == 2'd2) nlast++;
      end
      if (s_ready_o) ready_seen = 1'b1;
      if (s_ready_o && src_pos == stall_at && stall_left > 0) begin
        s_valid_i = 1'b0;
        stall_left--;
      end else begin
        s_valid_i = 1'b1;
        s_data_i  = src[src_pos];
        if (s_ready_o) src_pos++;
      end
    end
    s_valid_i = 1'b0;
    if (abort_at == 0) check_eq("last_beats", 64'(nlast), 64'd64);
  endtask

  task automatic check_stream(input int tot);
    int exp_nb;
    exp_nb = (tot == 0) ? 64 : ((tot + 63) / 64) * 64;
    check_eq("beat_count", 64'(nbeats), 64'(exp_nb));
    for (int i = 0; i < nbeats; i++) begin
      check_eq($sformatf("beat_cmd[%0d]", i), 64'(b_cmd[i]), (i >= exp_nb - 64) ? 64'd2 : 64'd1);
      check_eq($sformatf("beat_data[%0d]", i), 64'(b_data[i]), (i < tot) ? 64'(src[i]) : 64'd0);
    end
  endtask

  task automatic read_hash(input int nexp);
    repeat (3) @(negedge clk);
    check_eq("hash_v_idle", 64'(hash_v_o), 64'd0);
    hash_finished_i = 1'b1;
    hash_i = 8'd0;
    for (int j = 0; j < nexp; j++) begin
      @(negedge clk);
      check_eq("hash_v", 64'(hash_v_o), 64'd1);
      check_eq("hash_idx", 64'(hash_idx_o), 64'(j));
      check_eq("hash_data", 64'(hash_o), 64'(j));
      hash_i = 8'(j + 1);
    end
    @(negedge clk);
    check_eq("done", 64'(done_o), 64'd1);
    check_eq("busy_drop", 64'(busy_o), 64'd0);
    check_eq("hash_v_end", 64'(hash_v_o), 64'd0);
    hash_finished_i = 1'b0;
    hash_i = 8'd0;
    @(negedge clk);
    check_eq("done_pulse", 64'(done_o), 64'd0);
  endtask

  task automatic expect_timeout();
    int d;
    d = 0;
    while (error_o !== 1'b1 && d < 5000) begin
      @(negedge clk);
      d++;
    end
    check_eq("timeout_cycles", 64'(d), 64'd4096);
    check_eq("timeout_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    check_eq("error_pulse", 64'(error_o), 64'd0);
  endtask

  initial begin
    nreset = 1'b0; start_i = 1'b0; kk_i = 8'd0; nn_i = 8'd0; ll_i = 64'd0;
    s_valid_i = 1'b0; s_data_i = 8'd0; hash_finished_i = 1'b0; hash_i = 8'd0;
    for (int i = 0; i < 256; i++) src[i] = 8'(i * 7 + 3);
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 64'(outs_w), 64'd0);
    nreset = 1'b1;

    src[0] = 8'h61; src[1] = 8'h62; src[2] = 8'h63;
    run_job(8'd0, 8'd32, 64'd3, -1, 0, 0);
    $display("job kk=0 nn=32 ll=3: %0d beats, %0d LAST", nbeats, nlast);
    check_stream(3);
    read_hash(32);

    run_job(8'd0, 8'd0, 64'd0, -1, 0, 0);
    $display("job kk=0 nn=0 ll=0: %0d beats, ready_seen=%0d", nbeats, ready_seen);
    check_eq("ready_never_high", 64'(ready_seen), 64'd0);
    check_stream(0);
    read_hash(32);

    run_job(8'd0, 8'd5, 64'd64, -1, 0, 0);
    $display("job kk=0 nn=5 ll=64: %0d beats", nbeats);
    check_stream(64);
    check_eq("ll64_contiguous", 64'(b_cyc[63] - b_cyc[0]), 64'd63);
    read_hash(5);

    run_job(8'd0, 8'd40, 64'd65, -1, 0, 0);
    $display("job kk=0 nn=40 ll=65: %0d beats, gap span %0d", nbeats, b_cyc[64] - b_cyc[63]);
    check_stream(65);
    check_eq("block_gap_span", 64'(b_cyc[64] - b_cyc[63]), 64'd33);
    check_eq("block0_contiguous", 64'(b_cyc[63] - b_cyc[0]), 64'd63);
    read_hash(32);

    run_job(8'd1, 8'd16, 64'd20, 10, 5, 0);
    $display("job kk=1 nn=16 ll=20 stall@10x5: %0d beats, stall span %0d", nbeats, b_cyc[10] - b_cyc[9]);
    check_stream(84);
    check_eq("stall_span", 64'(b_cyc[10] - b_cyc[9]), 64'd6);
    check_eq("pre_stall_contiguous", 64'(b_cyc[9] - b_cyc[0]), 64'd9);
    expect_timeout();

    run_job(8'd0, 8'd32, 64'd100, -1, 0, 20);
    $display("job kk=0 nn=32 ll=100: reset after %0d beats", nbeats);
    check_eq("busy_mid_data", 64'(busy_o), 64'd1);
    nreset = 1'b0;
    @(negedge clk);
    check_eq("mid_reset_outputs", 64'(outs_w), 64'd0);
    nreset = 1'b1;

    run_job(8'd0, 8'd32, 64'd3, -1, 0, 0);
    $display("job after reset kk=0 nn=32 ll=3: %0d beats", nbeats);
    check_stream(3);
    read_hash(32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/blake2s_host_driver.md
# blake2s_host_driver

Host-side driver for the BLAKE2s pin protocol: the transmitting end that feeds the hash core's `valid`/`cmd`/`data` pins and reads back `hash`/`hash_finished`. It takes a configuration (key length, digest length, message length) and a byte stream from an upstream source. It serialises the configuration and 64-byte padded blocks onto the pins, paces the blocks, then captures the digest bytes. It lives on the FPGA/host side of the chip boundary and in system benches.

## Interface
- `BLOCK_GAP`, 32: idle cycles (valid_o low) inserted after every non-final block.
- `HASH_TIMEOUT`, 4095: max cycles in WAIT_HASH before aborting.
- `clk` in 1: single clock; all logic on rising edge.
- `nreset` in 1: reset is synchronous and active-low.
- `start_i` in 1: begin a job; sampled only in IDLE.
- `kk_i` in 8: key length, passed through in CONF.
- `nn_i` in 8: digest length; 0 or >32 treated as 32.
- `ll_i` in 64: message length in bytes.
- `s_valid_i` in 1, `s_data_i` in 8, `s_ready_o` out 1: upstream byte stream, transfer when both high.
- `busy_o` out 1: high from the cycle after start until return to IDLE.
- `hash_v_o` out 1, `hash_o` out 8, `hash_idx_o` out 5: captured digest byte and its index.
- `done_o` out 1: one-cycle pulse after the last digest byte.
- `error_o` out 1: one-cycle pulse on timeout.
- `valid_o` out 1, `cmd_o` out 2, `data_o` out 8: pin-side byte strobe, command, and data.
- `hash_finished_i` in 1, `hash_i` in 8: pin-side digest return.

## Operation
- Commands: 2'd0 CONF, 2'd1 DATA (byte of a non-final block), 2'd2 LAST (byte of the final block). 2'd3 is never driven.
- Upstream supplies `total = (kk_i != 0 ? 64 : 0) + ll_i` bytes, with the key already padded to 64. `total` is computed 65 bits wide and latched at start.
- Block count is `max(1, ceil(total/64))`.
- FSM states: IDLE, CONF, DATA, GAP, WAIT_HASH, READ.
- IDLE: on `start_i`, latch the configuration and go to CONF.
- CONF: 10 beats, `valid_o=1`, `cmd_o=0`. Data order is `kk`, `nn` (clamped), then `ll` bytes 0..7, LSB first. Then go to DATA.
- DATA: 6-bit byte index 0..63 within the block.
  - While consumed < total: `s_ready_o=1`. A beat is emitted only on an upstream transfer.
  - If `s_valid_i` is low, `valid_o=0` and the index holds.
  - Once consumed == total, the remaining beats of the block are zero pad with `s_ready_o=0`, one per cycle, no stalls.
  - `cmd_o` is LAST for every beat of the final block, else DATA.
- At index 63, the index wraps to 0. A non-final block goes to GAP; the final block goes to WAIT_HASH.
- GAP: `BLOCK_GAP` cycles with `valid_o=0`, then back to DATA.
- WAIT_HASH: wait for `hash_finished_i=1`, which moves to READ. If `HASH_TIMEOUT` cycles elapse first, pulse `error_o` and go to IDLE.
- READ: for `nn` consecutive cycles, starting the cycle `hash_finished_i` is first seen high:
  - `hash_o` is registered from `hash_i`, `hash_v_o=1`, `hash_idx_o` counts 0..nn-1.
  - After the last byte, pulse `done_o` and go to IDLE.
  - If `hash_finished_i` drops early, abort: pulse `error_o`, go to IDLE.
- `start_i` is ignored while not in IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- `nreset` low at any point, mid-job included, returns every output to 0 on the next edge and discards the job. There is no partial flush.
- `start_i` in cycle t gives the first CONF beat at t+1, with `busy_o=1` from t+1.
- Upstream transfer in cycle t gives the corresponding pin beat in cycle t+1. Pad beats follow the last data beat back-to-back.
- Last LAST beat in cycle t: WAIT_HASH from t+1. Timeout counts from t+1.
- `hash_i` sampled at edge k appears on `hash_o` at k+1. `done_o` is asserted one cycle after the final `hash_v_o`, and `busy_o` drops together with `done_o`.
- `s_ready_o` is never high outside DATA.

## Test plan
- kk=0, nn=32, ll=3, bytes 61 62 63:
  - CONF beats 00 20 03 00 00 00 00 00 00 00.
  - Then 64 LAST beats: 61 62 63 followed by 61 zeros.
  - `hash_finished_i` high with `hash_i` = 0..31 gives 32 `hash_v_o` pulses with idx == data == 0..31, then `done_o`.
- ll=0, kk=0: 64 LAST beats of 00, `s_ready_o` never high.
- ll=64: exactly 64 LAST beats, no pad, no GAP.
- ll=65: 64 DATA beats, then exactly 32 idle cycles, then 64 LAST beats (1 data byte + 63 zero pad).
- Upstream stall: `s_valid_i` low 5 cycles at byte 10 gives `valid_o` low 5 cycles, byte 10 sent next, no index skip.
- Error cases:
  - `hash_finished_i` held low gives `error_o` after 4095 WAIT_HASH cycles, then IDLE.
  - `nreset` low mid-DATA gives all outputs 0 next cycle, and a new `start_i` runs a clean job.
